alu_operand_sequencer: RTL

//  Multicycle control FSM that drives the select lines of the ALU operand muxes (source-B mux: 0=B reg, 1=const 4,
//  2=sign_extend, 3=sign_extend_sl2, 4=memory data register) plus the ALU op and datapath write strobes.
//  It is the driving end of the source-B select interface. Sits between instruction register decode and the datapath.

---
 rtl/alu_operand_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: multicycle control FSM for the ALU operand muxes.
// Define ALUSRCB_ADDM_EN to enable the addm (reg + memory) path.
module alu_operand_sequencer #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned SEL_W   = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             alu_src_a_sel,
   output logic [SEL_W-1:0] alu_src_b_sel,
   output logic [2:0]       alu_op,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mdr_write,
   output logic             reg_write,
   output logic             illegal,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_DECODE     = 4'd1,
      S_EXEC_R     = 4'd2,
      S_EXEC_I     = 4'd3,
      S_WB         = 4'd4,
      S_EXEC_BR    = 4'd5,
      S_MEM_ADDR   = 4'd6,
      S_MEM_WAIT   = 4'd7,
      S_TRAP       = 4'd8,
      S_MEM_ADDR_M = 4'd9,
      S_EXEC_M     = 4'd10
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;

   localparam logic [5:0] OPC_R    = 6'h00;
   localparam logic [5:0] OPC_ADDI = 6'h08;
   localparam logic [5:0] OPC_BEQ  = 6'h04;
   localparam logic [5:0] OPC_BNE  = 6'h05;
   localparam logic [5:0] OPC_LW   = 6'h23;
   localparam logic [5:0] OPC_SW   = 6'h2b;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
`ifdef ALUSRCB_ADDM_EN
   localparam logic [5:0] FN_ADDM = 6'h05;
`endif

   state_t     state_q, state_d, dec_state;
   logic [3:0] cnt_q, cnt_d;
   logic [5:0] opc_q, opc_d;
   logic [5:0] fn_q, fn_d;
   logic       illegal_q, illegal_d;

   logic       a_c;
   logic [2:0] b_c;
   logic [2:0] op_c;
   logic       pcw_c, irw_c, rd_c, wr_c, mdr_c, rw_c;

   // Classify the live instruction bits; only consumed in DECODE
   always_comb begin
      dec_state = S_TRAP;
      case (opcode)
         OPC_R: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR: dec_state = S_EXEC_R;
`ifdef ALUSRCB_ADDM_EN
               FN_ADDM: dec_state = S_MEM_ADDR_M;
`endif
               default: dec_state = S_TRAP;
            endcase
         end
         OPC_ADDI:         dec_state = S_EXEC_I;
         OPC_BEQ, OPC_BNE: dec_state = S_EXEC_BR;
         OPC_LW, OPC_SW:   dec_state = S_MEM_ADDR;
         default:          dec_state = S_TRAP;
      endcase
   end

   // Next-state, wait counter and Moore control outputs per state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      opc_d     = opc_q;
      fn_d      = fn_q;
      illegal_d = illegal_q;
      a_c       = 1'b0;
      b_c       = 3'd0;
      op_c      = OP_ADD;
      pcw_c     = 1'b0;
      irw_c     = 1'b0;
      rd_c      = 1'b0;
      wr_c      = 1'b0;
      mdr_c     = 1'b0;
      rw_c      = 1'b0;
      case (state_q)
         S_FETCH: begin
            b_c  = 3'd1;
            rd_c = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            b_c     = 3'd3;
            opc_d   = opcode;
            fn_d    = funct;
            state_d = dec_state;
            if (dec_state == S_TRAP) illegal_d = 1'b1;
         end
         S_EXEC_R: begin
            a_c = 1'b1;
            case (fn_q)
               FN_SUB:  op_c = OP_SUB;
               FN_AND:  op_c = OP_AND;
               FN_OR:   op_c = OP_OR;
               default: op_c = OP_ADD;
            endcase
            state_d = S_WB;
         end
         S_EXEC_I: begin
            a_c     = 1'b1;
            b_c     = 3'd2;
            state_d = S_WB;
         end
         S_WB: begin
            rw_c    = 1'b1;
            cnt_d   = LAT_M1;
            state_d = S_FETCH;
         end
         S_EXEC_BR: begin
            a_c     = 1'b1;
            op_c    = OP_SUB;
            pcw_c   = ((opc_q == OPC_BEQ) &&  zero) ||
                      ((opc_q == OPC_BNE) && !zero);
            cnt_d   = LAT_M1;
            state_d = S_FETCH;
         end
         S_MEM_ADDR, S_MEM_ADDR_M: begin
            a_c     = 1'b1;
            b_c     = 3'd2;
            cnt_d   = LAT_M1;
            state_d = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            if (opc_q == OPC_SW) wr_c = 1'b1;
            else rd_c = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (opc_q == OPC_SW) begin
               cnt_d   = LAT_M1;
               state_d = S_FETCH;
            end else begin
               mdr_c = 1'b1;
`ifdef ALUSRCB_ADDM_EN
               state_d = (opc_q == OPC_R) ? S_EXEC_M : S_WB;
`else
               state_d = S_WB;
`endif
            end
         end
`ifdef ALUSRCB_ADDM_EN
         S_EXEC_M: begin
            a_c     = 1'b1;
            b_c     = 3'd4;
            state_d = S_WB;
         end
`endif
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            cnt_d   = LAT_M1;
            state_d = S_FETCH;
         end
      endcase
   end

   // State, counter, latched instruction fields and sticky trap flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_FETCH;
         cnt_q     <= LAT_M1;
         opc_q     <= 6'h00;
         fn_q      <= 6'h00;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opc_q     <= opc_d;
         fn_q      <= fn_d;
         illegal_q <= illegal_d;
      end
   end

   // Outputs are forced quiet while reset is held, aborting at once
   always_comb begin
      alu_src_a_sel = reset_n & a_c;
      alu_src_b_sel = reset_n ? SEL_W'(b_c) : '0;
      alu_op        = reset_n ? op_c : OP_ADD;
      pc_write      = reset_n & pcw_c;
      ir_write      = reset_n & irw_c;
      mem_read      = reset_n & rd_c;
      mem_write     = reset_n & wr_c;
      mdr_write     = reset_n & mdr_c;
      reg_write     = reset_n & rw_c;
      illegal       = illegal_q;
      state_o       = state_q;
   end

endmodule
